// File: rtl/tdm_port_adapter.sv
// TDM port adapter: demultiplexes a serial byte stream into per-port lanes with packet
// framing checks, and multiplexes per-port egress bytes back out. Define TDM_SYNC_EN to add frame_sync.
module tdm_port_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 12,
    localparam int SLOT_W    = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
`ifdef TDM_SYNC_EN
    input  logic                            frame_sync,
`endif
    input  logic                            in_valid,
    input  logic                            in_new_packet,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic [SLOT_W-1:0]               slot,
    output logic [NUM_PORTS-1:0]            port_valid,
    output logic [NUM_PORTS-1:0]            port_newpkt,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] port_data,
    input  logic [NUM_PORTS-1:0]            ret_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] ret_data,
    output logic [NUM_PORTS-1:0]            ret_ready,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [NUM_PORTS-1:0]            frame_err
);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } frame_state_t;

    logic [SLOT_W-1:0]     slot_next;
    logic [NUM_PORTS-1:0]  slot_hit;
    frame_state_t          state_q [NUM_PORTS];
    frame_state_t          state_d [NUM_PORTS];
    logic [NUM_PORTS-1:0]  fwd;
    logic [NUM_PORTS-1:0]  err_set;
    logic [NUM_PORTS-1:0]  hold_full;
    logic [DATA_WIDTH-1:0] hold_data [NUM_PORTS];
    logic [NUM_PORTS-1:0]  take;
    logic [NUM_PORTS-1:0]  emit;
    logic [DATA_WIDTH-1:0] emit_data;

    // ---------------- slot counter ----------------
    always_comb begin
        slot_next = (slot == SLOT_W'(NUM_PORTS - 1)) ? '0 : slot + SLOT_W'(1);
`ifdef TDM_SYNC_EN
        if (frame_sync)
            slot_next = '0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            slot <= '0;
        else
            slot <= slot_next;
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++)
            slot_hit[p] = (slot == SLOT_W'(p));
    end

    // ---------------- ingress framing FSMs ----------------
    // NOTE: every combinational output gets a default before any branch, so no latches are inferred.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            state_d[p] = state_q[p];
            fwd[p]     = 1'b0;
            err_set[p] = 1'b0;
            if (slot_hit[p] && in_valid) begin
                case (state_q[p])
                    IDLE: begin
                        if (in_new_packet) begin
                            state_d[p] = PKT;
                            fwd[p]     = 1'b1;
                        end else begin
                            err_set[p] = 1'b1;
                        end
                    end
                    PKT:     fwd[p] = 1'b1;
                    default: state_d[p] = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NUM_PORTS; p++)
                state_q[p] <= IDLE;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++)
                state_q[p] <= state_d[p];
        end
    end

    // Non-addressed lanes are driven to zero rather than holding stale bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_valid  <= '0;
            port_newpkt <= '0;
            port_data   <= '0;
            frame_err   <= '0;
        end else begin
            port_valid  <= fwd;
            port_newpkt <= fwd & {NUM_PORTS{in_new_packet}};
            frame_err   <= frame_err | err_set;
            for (int p = 0; p < NUM_PORTS; p++)
                port_data[p*DATA_WIDTH +: DATA_WIDTH] <= fwd[p] ? in_data : '0;
        end
    end

    // ---------------- egress hold registers ----------------
    // A port may refill its hold register in the same cycle that its slot drains it.
    assign ret_ready = ~hold_full | slot_hit;
    assign take      = ret_valid & ret_ready;
    assign emit      = hold_full & slot_hit;

    always_comb begin
        emit_data = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (emit[p])
                emit_data = hold_data[p];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            hold_full <= '0;
        else
            hold_full <= (hold_full & ~emit) | take;
    end

    // NOTE: hold_data needs no reset; hold_full gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++)
            if (take[p])
                hold_data[p] <= ret_data[p*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= |emit;
            out_data  <= emit_data;
        end
    end

endmodule

// File: tb/tb_tdm_port_adapter.sv
// Self-checking bench for tdm_port_adapter: directed scenarios plus randomized traffic
// compared cycle by cycle against a slot-indexed behavioural model.
module tb_tdm_port_adapter;

    localparam int NP = 12;
    localparam int DW = 8;
    localparam int SW = 4;

    logic              clk = 1'b0;
    logic              rst;
`ifdef TDM_SYNC_EN
    logic              frame_sync;
`endif
    logic              in_valid;
    logic              in_new_packet;
    logic [DW-1:0]     in_data;
    logic [SW-1:0]     slot;
    logic [NP-1:0]     port_valid;
    logic [NP-1:0]     port_newpkt;
    logic [NP*DW-1:0]  port_data;
    logic [NP-1:0]     ret_valid;
    logic [NP*DW-1:0]  ret_data;
    logic [NP-1:0]     ret_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [NP-1:0]     frame_err;

    tdm_port_adapter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef TDM_SYNC_EN
        .frame_sync    (frame_sync),
`endif
        .in_valid      (in_valid),
        .in_new_packet (in_new_packet),
        .in_data       (in_data),
        .slot          (slot),
        .port_valid    (port_valid),
        .port_newpkt   (port_newpkt),
        .port_data     (port_data),
        .ret_valid     (ret_valid),
        .ret_data      (ret_data),
        .ret_ready     (ret_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: which slot is current, which ports are inside a packet,
    // and what each port's single egress buffer holds.
    int            m_slot;
    int            prev_slot;
    bit            m_inpkt [NP];
    bit            m_full  [NP];
    logic [DW-1:0] m_hold  [NP];
    logic [NP-1:0] m_err;
    logic [NP-1:0]    exp_pv, exp_pn, exp_ready;
    logic [NP*DW-1:0] exp_pd;
    logic             exp_ov;
    logic [DW-1:0]    exp_od;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = 0;
        m_err  = '0;
        for (int p = 0; p < NP; p++) begin
            m_inpkt[p] = 1'b0;
            m_full[p]  = 1'b0;
            m_hold[p]  = '0;
        end
    endtask

    // Called shortly after a rising edge with inputs already applied; advances one cycle.
    task automatic tick();
        int s;
        s = m_slot;
        prev_slot = s;
        for (int p = 0; p < NP; p++)
            exp_ready[p] = !m_full[p] || (p == s);
        check("slot", slot, m_slot);
        check("ret_ready", ret_ready, exp_ready);

        exp_pv = '0;
        exp_pn = '0;
        exp_pd = '0;
        if (in_valid) begin
            if (m_inpkt[s] || in_new_packet) begin
                exp_pv[s] = 1'b1;
                exp_pn[s] = in_new_packet;
                exp_pd[s*DW +: DW] = in_data;
                m_inpkt[s] = 1'b1;
            end else begin
                m_err[s] = 1'b1;
            end
        end

        exp_ov = m_full[s];
        exp_od = m_full[s] ? m_hold[s] : '0;
        for (int p = 0; p < NP; p++) begin
            if (ret_valid[p] && exp_ready[p]) begin
                m_full[p] = 1'b1;
                m_hold[p] = ret_data[p*DW +: DW];
            end else if (p == s) begin
                m_full[p] = 1'b0;
            end
        end

        m_slot = (s + 1) % NP;
`ifdef TDM_SYNC_EN
        if (frame_sync)
            m_slot = 0;
`endif

        @(posedge clk);
        #1;
        check("port_valid", port_valid, exp_pv);
        check("port_newpkt", port_newpkt, exp_pn);
        check("port_data", port_data, exp_pd);
        check("out_valid", out_valid, exp_ov);
        check("out_data", out_data, exp_od);
        check("frame_err", frame_err, m_err);
    endtask

    task automatic advance_to(input int target);
        for (int i = 0; i < NP + 1; i++) begin
            if (m_slot == target)
                break;
            tick();
        end
        check("advance_reached", m_slot, target);
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        in_new_packet = 1'b0;
        in_data       = '0;
        ret_valid     = '0;
        ret_data      = '0;
    endtask

    initial begin
        logic [DW-1:0] q [$];
        logic [DW-1:0] em_val [$];
        int            em_cyc [$];
        bit            acc;

        idle_inputs();
`ifdef TDM_SYNC_EN
        frame_sync = 1'b0;
`endif
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_slot", slot, 0);
        check("reset_port_valid", port_valid, 0);
        check("reset_port_data", port_data, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_frame_err", frame_err, 0);
        rst = 1'b1;

        // Wrap: 0..11 then back to 0.
        for (int i = 0; i < NP + 1; i++) begin
            check("wrap_seq", slot, i % NP);
            check("wrap_range", slot < NP, 1'b1);
            tick();
        end

        // Demux into slot 5.
        advance_to(5);
        in_valid = 1'b1; in_new_packet = 1'b1; in_data = 8'hA5;
        tick();
        idle_inputs();
        check("demux_valid", port_valid, 12'h020);
        check("demux_lane5", port_data[47:40], 8'hA5);
        check("demux_others", port_data & ~(96'hFF << 40), 0);

        // Orphan byte into IDLE port 3.
        advance_to(3);
        in_valid = 1'b1; in_new_packet = 1'b0; in_data = 8'h77;
        tick();
        idle_inputs();
        check("frame_drop_valid", port_valid, 0);
        check("frame_err3", frame_err[3], 1'b1);
        repeat (NP) tick();
        check("frame_err3_sticky", frame_err[3], 1'b1);

        // Egress on port 7.
        ret_valid[7] = 1'b1;
        ret_data[7*DW +: DW] = 8'h3C;
        tick();
        if (m_slot != 7)
            check("egress_ready_low", ret_ready[7], 1'b0);
        advance_to(7);
        tick();
        check("egress_valid", out_valid, 1'b1);
        check("egress_data", out_data, 8'h3C);
        idle_inputs();
        repeat (NP) tick();

        // Back-to-back 0x01,0x02,0x03 on port 0.
        q = '{8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 6 * NP && em_val.size() < 3; i++) begin
            if (q.size() > 0) begin
                ret_valid[0] = 1'b1;
                ret_data[DW-1:0] = q[0];
            end else begin
                ret_valid[0] = 1'b0;
            end
            acc = ret_valid[0] && ret_ready[0];
            tick();
            if (acc)
                void'(q.pop_front());
            if (prev_slot == 0 && out_valid) begin
                em_val.push_back(out_data);
                em_cyc.push_back(i);
            end
        end
        idle_inputs();
        check("b2b_count", em_val.size(), 3);
        for (int k = 0; k < em_val.size(); k++)
            check("b2b_order", em_val[k], k + 1);
        for (int k = 1; k < em_cyc.size(); k++)
            check("b2b_frame_gap", em_cyc[k] - em_cyc[k-1], NP);

`ifdef TDM_SYNC_EN
        advance_to(6);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("sync_slot", slot, 0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid      = 1'($urandom_range(0, 1));
            in_new_packet = ($urandom_range(0, 3) == 0);
            in_data       = DW'($urandom);
            ret_valid     = NP'($urandom);
            for (int p = 0; p < NP; p++)
                ret_data[p*DW +: DW] = DW'($urandom);
            tick();
        end

        // Fill holders, then reset mid-packet: held bytes must vanish.
        ret_valid = '1;
        ret_data  = {NP{8'hEE}};
        in_valid = 1'b1; in_new_packet = 1'b1; in_data = 8'h11;
        tick();
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("midrst_slot", slot, 0);
        check("midrst_port_valid", port_valid, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_frame_err", frame_err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (NP + 2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
